// File: rtl/lisnoc_def.sv
// Shared LISNoC definitions: flit type codes, arbiter state encoding,
// the type-field slice macro and a constant-evaluable clog2.
`ifndef LISNOC_FLIT_TYPE
`define LISNOC_FLIT_TYPE(flit, dw, tw) flit[(dw)+(tw)-1:(dw)]
`endif

package lisnoc_def;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lisnoc_rr_select.sv
// Combinational round-robin selector: picks the first set request bit
// searching circularly upward from rr_ptr. Shared with the VC allocator.
module lisnoc_rr_select #(
  parameter int PORTS = 4,
  parameter int PTR_W = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PORTS-1:0] winner_onehot,
  output logic [PTR_W-1:0] winner_idx,
  output logic             winner_valid
);

  // Scan from the farthest candidate back to rr_ptr so the closest one wins.
  always_comb begin
    int sum_v;
    int pos_v;
    winner_onehot = '0;
    winner_idx    = '0;
    winner_valid  = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      sum_v = int'(rr_ptr) + k;
      // Explicit wrap so non power-of-two port counts stay in range.
      pos_v = (sum_v >= PORTS) ? (sum_v - PORTS) : sum_v;
      if (req[pos_v]) begin
        winner_onehot        = '0;
        winner_onehot[pos_v] = 1'b1;
        winner_idx           = PTR_W'(pos_v);
        winner_valid         = 1'b1;
      end else begin
        winner_valid = winner_valid;
      end
    end
  end

endmodule

// File: rtl/lisnoc_packet_arbiter.sv
// Wormhole packet arbiter: round-robin among requesters at packet start,
// grant locked from header through last flit. Datapath is combinational;
// arbitration state and the framing error pulse are registered.
module lisnoc_packet_arbiter
  import lisnoc_def::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int PORTS           = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS*(flit_data_width+flit_type_width)-1:0] in_flit,
  input  logic [PORTS-1:0]                  in_valid,
  output logic [PORTS-1:0]                  in_ready,
  output logic [flit_data_width+flit_type_width-1:0] out_flit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PORTS-1:0]                  grant,
  output logic                              err_framing
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int PTR_W      = (clog2(PORTS) < 1) ? 1 : clog2(PORTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PORTS - 1);

  arb_state_e       state_r, state_nxt_s;
  logic [PTR_W-1:0] owner_r, owner_nxt_s;
  logic [PTR_W-1:0] rr_ptr_r, rr_nxt_s;
  logic             pkt_start_r, pkt_start_nxt_s;
  logic             err_framing_r, err_nxt_s;

  logic [PORTS-1:0]           win_onehot_s;
  logic [PTR_W-1:0]           win_idx_s;
  logic                       win_valid_s;
  logic [PTR_W-1:0]           sel_idx_s;
  logic [flit_width-1:0]      out_flit_s;
  logic [flit_type_width-1:0] type_s;
  logic [PORTS-1:0]           grant_s;
  logic                       out_valid_s;
  logic                       xfer_s;
  logic                       is_end_s;
  logic                       start_s;

  // Next round-robin pointer with explicit wrap at PORTS-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? PTR_W'(1'b0) : (p + PTR_W'(1'b1));
  endfunction

  lisnoc_rr_select #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req           (in_valid),
    .rr_ptr        (rr_ptr_r),
    .winner_onehot (win_onehot_s),
    .winner_idx    (win_idx_s),
    .winner_valid  (win_valid_s)
  );

  // Output selection: locked owner, or the fresh round-robin winner; reset blanks it.
  always_comb begin
    grant_s     = '0;
    out_valid_s = 1'b0;
    sel_idx_s   = win_idx_s;
    if (rst) begin
      grant_s     = '0;
      out_valid_s = 1'b0;
    end else if (state_r == ST_LOCKED) begin
      sel_idx_s          = owner_r;
      grant_s[owner_r]   = 1'b1;
      out_valid_s        = in_valid[owner_r];
    end else begin
      grant_s     = win_onehot_s;
      out_valid_s = win_valid_s;
    end
    out_flit_s = in_flit[int'(sel_idx_s)*flit_width +: flit_width];
  end

  assign type_s   = `LISNOC_FLIT_TYPE(out_flit_s, flit_data_width, flit_type_width);
  assign xfer_s   = out_valid_s & out_ready;
  assign is_end_s = (type_s == FLIT_LAST) | (type_s == FLIT_SINGLE);
  // Packet start: nothing of the current packet has been transferred yet.
  assign start_s  = (state_r == ST_IDLE) | pkt_start_r;

  assign out_flit    = out_flit_s;
  assign out_valid   = out_valid_s;
  assign grant       = grant_s;
  assign in_ready    = grant_s & {PORTS{out_ready}};
  assign err_framing = err_framing_r;

  // Lock / round-robin next-state and framing error detection.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    rr_nxt_s        = rr_ptr_r;
    pkt_start_nxt_s = pkt_start_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          if (xfer_s && is_end_s) begin
            rr_nxt_s        = ptr_inc(win_idx_s);
            pkt_start_nxt_s = 1'b1;
          end else begin
            // Header sent, or stalled: lock so out_flit stays stable.
            state_nxt_s     = ST_LOCKED;
            owner_nxt_s     = win_idx_s;
            pkt_start_nxt_s = ~xfer_s;
          end
        end else begin
          pkt_start_nxt_s = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && is_end_s) begin
          state_nxt_s     = ST_IDLE;
          rr_nxt_s        = ptr_inc(owner_r);
          pkt_start_nxt_s = 1'b1;
        end else if (xfer_s) begin
          pkt_start_nxt_s = 1'b0;
        end else begin
          pkt_start_nxt_s = pkt_start_r;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        pkt_start_nxt_s = 1'b1;
      end
    endcase
    err_nxt_s = xfer_s & (( start_s & ((type_s == FLIT_PAYLOAD) | (type_s == FLIT_LAST))) |
                          (~start_s & (type_s == FLIT_HEADER)));
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      owner_r       <= '0;
      rr_ptr_r      <= '0;
      pkt_start_r   <= 1'b1;
      err_framing_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      owner_r       <= owner_nxt_s;
      rr_ptr_r      <= rr_nxt_s;
      pkt_start_r   <= pkt_start_nxt_s;
      err_framing_r <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_lisnoc_packet_arbiter.sv
// Self-checking bench for lisnoc_packet_arbiter: per-scenario tasks with
// inline checks plus a scoreboard of expected output transfers.
module tb_lisnoc_packet_arbiter;

  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int PORTS = 4;
  localparam int FW    = DW + TW;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  logic                clk = 1'b0;
  logic                rst;
  logic [PORTS*FW-1:0] in_flit;
  logic [PORTS-1:0]    in_valid;
  logic [PORTS-1:0]    in_ready;
  logic [FW-1:0]       out_flit;
  logic                out_valid;
  logic                out_ready;
  logic [PORTS-1:0]    grant;
  logic                err_framing;

  typedef struct packed {
    int            port;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  lisnoc_packet_arbiter #(
    .flit_data_width (DW),
    .flit_type_width (TW),
    .PORTS           (PORTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .err_framing (err_framing)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted output flit must match the next expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got flit=%h grant=%b, required no transfer", out_flit, grant);
      end else begin
        mon_e = sb_q.pop_front();
        if (out_flit !== mon_e.flit || grant !== (4'b0001 << mon_e.port)) begin
          failures++;
          $display("FAIL sb_xfer: got flit=%h grant=%b, required flit=%h port=%0d",
                   out_flit, grant, mon_e.flit, mon_e.port);
        end
      end
    end
  end

  task automatic set_port(input int p, input logic [1:0] t, input logic [31:0] d, input logic v);
    in_flit[p*FW +: FW] = {t, d};
    in_valid[p]         = v;
  endtask

  task automatic expect_xfer(input int p, input logic [1:0] t, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.flit = {t, d};
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int p = 0; p < PORTS; p++) set_port(p, T_SGL, 32'h100 + p, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (grant !== 4'b0000) begin
        failures++; $display("FAIL reset_grant: got %b, required 0000", grant);
      end
      checks++;
      if (err_framing !== 1'b0 && c == 1) begin
        failures++; $display("FAIL reset_err: got %b, required 0", err_framing);
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      expect_xfer(order[k], T_SGL, 32'h100 + order[k]);
      @(negedge clk);
      checks++;
      if (grant !== (4'b0001 << order[k])) begin
        failures++; $display("FAIL rr_grant_%0d: got %b, required port %0d", k, grant, order[k]);
      end
      next_cycle();
    end
    in_valid = '0;
  endtask

  task automatic test_wormhole();
    logic [1:0] types[3] = '{T_HDR, T_PAY, T_LST};
    set_port(2, T_SGL, 32'hB0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_port(1, types[k], 32'hA1 + k, 1'b1);
      expect_xfer(1, types[k], 32'hA1 + k);
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || in_ready[2] !== 1'b0) begin
        failures++; $display("FAIL wh_lock_%0d: got grant=%b in_ready=%b, required 0010 / bit2=0", k, grant, in_ready);
      end
      next_cycle();
    end
    set_port(1, T_PAY, 32'h0, 1'b0);
    expect_xfer(2, T_SGL, 32'hB0);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin
      failures++; $display("FAIL wh_next: got %b, required 0100", grant);
    end
    next_cycle();
    set_port(2, T_SGL, 32'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_port(3, T_HDR, 32'hC1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_port(0, T_SGL, 32'hD0, 1'b1);
      @(negedge clk);
      checks++;
      if (grant !== 4'b1000 || out_flit !== {T_HDR, 32'hC1} || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_stable_%0d: got grant=%b flit=%h valid=%b in_ready=%b, required 1000 / %h / 1 / 0000",
                 k, grant, out_flit, out_valid, in_ready, {T_HDR, 32'hC1});
      end
      next_cycle();
    end
    out_ready = 1'b1;
    expect_xfer(3, T_HDR, 32'hC1);
    next_cycle();
    set_port(3, T_LST, 32'hC2, 1'b1);
    expect_xfer(3, T_LST, 32'hC2);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b0) begin
      failures++; $display("FAIL bp_err: got %b, required 0", err_framing);
    end
    next_cycle();
    set_port(3, T_LST, 32'h0, 1'b0);
    expect_xfer(0, T_SGL, 32'hD0);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL bp_port0_after: got %b, required 0001", grant);
    end
    next_cycle();
    set_port(0, T_SGL, 32'h0, 1'b0);
  endtask

  task automatic test_bubble_reset();
    set_port(0, T_HDR, 32'hE1, 1'b1);
    expect_xfer(0, T_HDR, 32'hE1);
    next_cycle();
    set_port(0, T_PAY, 32'hE2, 1'b0);
    set_port(1, T_SGL, 32'hF0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || grant !== 4'b0001 || in_ready !== 4'b0001) begin
        failures++;
        $display("FAIL bubble_%0d: got valid=%b grant=%b in_ready=%b, required 0 / 0001 / 0001",
                 k, out_valid, grant, in_ready);
      end
      next_cycle();
    end
    rst = 1'b1;
    set_port(0, T_SGL, 32'h60, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000) begin
      failures++; $display("FAIL bubble_rst: got valid=%b grant=%b, required 0 / 0000", out_valid, grant);
    end
    next_cycle();
    rst = 1'b0;
    expect_xfer(0, T_SGL, 32'h60);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL bubble_after_rst: got %b, required 0001", grant);
    end
    next_cycle();
    set_port(0, T_SGL, 32'h0, 1'b0);
    expect_xfer(1, T_SGL, 32'hF0);
    next_cycle();
    set_port(1, T_SGL, 32'h0, 1'b0);
  endtask

  task automatic test_framing();
    set_port(2, T_PAY, 32'h71, 1'b1);
    expect_xfer(2, T_PAY, 32'h71);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b0 || grant !== 4'b0100) begin
      failures++; $display("FAIL fr_pay_start: got err=%b grant=%b, required 0 / 0100", err_framing, grant);
    end
    next_cycle();
    set_port(2, T_LST, 32'h72, 1'b1);
    expect_xfer(2, T_LST, 32'h72);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b1 || grant !== 4'b0100) begin
      failures++; $display("FAIL fr_pulse: got err=%b grant=%b, required 1 / 0100", err_framing, grant);
    end
    next_cycle();
    set_port(2, T_LST, 32'h0, 1'b0);
    set_port(0, T_SGL, 32'h80, 1'b1);
    set_port(3, T_SGL, 32'h83, 1'b1);
    expect_xfer(3, T_SGL, 32'h83);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b0 || grant !== 4'b1000) begin
      failures++; $display("FAIL fr_after_rr3: got err=%b grant=%b, required 0 / 1000", err_framing, grant);
    end
    next_cycle();
    set_port(3, T_SGL, 32'h0, 1'b0);
    expect_xfer(0, T_SGL, 32'h80);
    next_cycle();
    set_port(0, T_SGL, 32'h0, 1'b0);
    // Header arriving mid-packet is flagged.
    set_port(1, T_HDR, 32'h91, 1'b1);
    expect_xfer(1, T_HDR, 32'h91);
    next_cycle();
    set_port(1, T_HDR, 32'h92, 1'b1);
    expect_xfer(1, T_HDR, 32'h92);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b0) begin
      failures++; $display("FAIL fr_hdr_first: got %b, required 0", err_framing);
    end
    next_cycle();
    set_port(1, T_LST, 32'h93, 1'b1);
    expect_xfer(1, T_LST, 32'h93);
    @(negedge clk);
    checks++;
    if (err_framing !== 1'b1) begin
      failures++; $display("FAIL fr_hdr_mid: got %b, required 1", err_framing);
    end
    next_cycle();
    set_port(1, T_LST, 32'h0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_flit   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_bubble_reset();
    test_framing();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
